// File: rtl/traceback_unit.sv
// traceback_unit: walks the stored direction matrix back from the best-score cell and streams edit ops.
// Ports: clk/reset_i (async active-low); start + tb_x_i/tb_y_i begin a walk;
// mem_block_num/column_num address the direction SRAM, column_k0 returns its 80-bit word a cycle later;
// op_o/op_valid/op_ready carry ops (0 diag, 1 deletion, 2 insertion); busy, done, end_x/end_y report status.
module traceback_unit #(
    parameter int ADDRESS_WIDTH   = 10,
    parameter int MEM_BLOCK_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       start,
    input  logic [ADDRESS_WIDTH-1:0]   tb_x_i,
    input  logic [ADDRESS_WIDTH-1:0]   tb_y_i,
    output logic [MEM_BLOCK_WIDTH-1:0] mem_block_num,
    output logic [ADDRESS_WIDTH-1:0]   column_num,
    input  logic [79:0]                column_k0,
    output logic [1:0]                 op_o,
    output logic                       op_valid,
    input  logic                       op_ready,
    output logic                       busy,
    output logic                       done,
    output logic [ADDRESS_WIDTH-1:0]   end_x,
    output logic [ADDRESS_WIDTH-1:0]   end_y
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FETCH, S_DECODE, S_EMIT, S_FIN} state_t;
    typedef enum logic [2:0] {G_H, G_E, G_EH, G_F, G_FH} gap_t;
    state_t                   r_state;
    gap_t                     r_g;
    logic [ADDRESS_WIDTH-1:0] r_x;
    logic [ADDRESS_WIDTH-1:0] r_y;
    logic [4:0]               r_dir;
    logic [6:0]               w_shift;
    logic [4:0]               w_field;
    logic [2:0]               w_src;
    logic [ADDRESS_WIDTH-1:0] w_nx;
    logic [ADDRESS_WIDTH-1:0] w_ny;
    assign mem_block_num = MEM_BLOCK_WIDTH'(r_y >> 4);
    assign column_num    = r_x;
    assign busy          = r_state != S_IDLE;
    // row r occupies column_k0[79-5r -: 5]
    assign w_shift = 7'(75 - 5 * int'(r_y[3:0]));
    assign w_field = 5'(column_k0 >> w_shift);
    assign w_src   = r_dir[2:0];
    // the coordinate move decided in DECODE is applied at the EMIT handshake so the
    // SRAM address stays put until the consumer takes the op
    assign w_nx = (op_o == 2'd2) ? r_x : r_x - 1'b1;
    assign w_ny = (op_o == 2'd1) ? r_y : r_y - 1'b1;
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= S_IDLE;
            r_g      <= G_H;
            r_x      <= '0;
            r_y      <= '0;
            r_dir    <= '0;
            op_o     <= '0;
            op_valid <= 1'b0;
            done     <= 1'b0;
            end_x    <= '0;
            end_y    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_x <= tb_x_i;
                    r_y <= tb_y_i;
                    r_g <= G_H;
                    if (tb_x_i == '0 || tb_y_i == '0) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                        end_x   <= tb_x_i;
                        end_y   <= tb_y_i;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_FETCH;
                S_FETCH: begin
                    r_dir   <= w_field;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (r_g == G_H) begin
                        if (w_src == 3'd1) begin
                            op_o     <= 2'd0;
                            op_valid <= 1'b1;
                            r_state  <= S_EMIT;
                        end else if (w_src >= 3'd2 && w_src <= 3'd5) begin
                            // src 2..5 maps onto E, EH, F, FH; decode again from the same word
                            r_g <= gap_t'(w_src - 3'd1);
                        end else begin
                            r_state <= S_FIN;
                            done    <= 1'b1;
                            end_x   <= r_x;
                            end_y   <= r_y;
                        end
                    end else if (r_g == G_E || r_g == G_EH) begin
                        op_o     <= 2'd1;
                        op_valid <= 1'b1;
                        r_g      <= r_dir[3] ? r_g : G_H;
                        r_state  <= S_EMIT;
                    end else begin
                        op_o     <= 2'd2;
                        op_valid <= 1'b1;
                        r_g      <= r_dir[4] ? r_g : G_H;
                        r_state  <= S_EMIT;
                    end
                end
                S_EMIT: if (op_ready) begin
                    op_valid <= 1'b0;
                    op_o     <= 2'd0;
                    r_x      <= w_nx;
                    r_y      <= w_ny;
                    if (w_nx == '0 || w_ny == '0) begin
                        r_state <= S_FIN;
                        done    <= 1'b1;
                        end_x   <= w_nx;
                        end_y   <= w_ny;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_FIN: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_unit.sv
// tb_traceback_unit: randomized and directed check of traceback_unit against a behavioural walk model.
module tb_traceback_unit;
    localparam int AW  = 10;
    localparam int MBW = 6;
    logic           clk = 1'b0;
    logic           reset_i = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  tb_x_i = '0;
    logic [AW-1:0]  tb_y_i = '0;
    logic [MBW-1:0] mem_block_num;
    logic [AW-1:0]  column_num;
    logic [79:0]    column_k0 = '0;
    logic [1:0]     op_o;
    logic           op_valid;
    logic           op_ready = 1'b1;
    logic           busy;
    logic           done;
    logic [AW-1:0]  end_x;
    logic [AW-1:0]  end_y;
    traceback_unit #(.ADDRESS_WIDTH(AW), .MEM_BLOCK_WIDTH(MBW)) dut (
        .clk(clk), .reset_i(reset_i), .start(start), .tb_x_i(tb_x_i), .tb_y_i(tb_y_i),
        .mem_block_num(mem_block_num), .column_num(column_num), .column_k0(column_k0),
        .op_o(op_o), .op_valid(op_valid), .op_ready(op_ready), .busy(busy), .done(done),
        .end_x(end_x), .end_y(end_y)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [1:0]  op;
        logic [9:0]  x;
        logic [9:0]  y;
    } exp_t;
    int         checks = 0;
    int         failures = 0;
    logic [4:0] dirm [64][64];
    exp_t       exp_q [$];
    int         exp_end_x = 0;
    int         exp_end_y = 0;
    bit         exp_active = 1'b0;
    int         rdy_mode = 0;
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask
    function automatic logic [79:0] word(input logic [MBW-1:0] b, input logic [AW-1:0] c);
        logic [79:0] w;
        w = '0;
        for (int r = 0; r < 16; r++) begin
            int yy;
            yy = int'(b) * 16 + r;
            if (int'(c) < 64 && yy < 64) w[79-5*r -: 5] = dirm[c[5:0]][yy[5:0]];
        end
        return w;
    endfunction
    always @(posedge clk) column_k0 <= word(mem_block_num, column_num);
    task automatic clear_dirm();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++)
                dirm[i][j] = 5'd0;
    endtask
    // walk model: g is 0 in H, 1 in an x-gap (E or E_hat), 2 in a y-gap (F or F_hat)
    task automatic model(input int sx, input int sy);
        int x, y, g;
        logic [4:0] w;
        exp_t e;
        x = sx;
        y = sy;
        g = 0;
        exp_q.delete();
        if (x != 0 && y != 0) begin
            for (int k = 0; k < 256; k++) begin
                w = dirm[x][y];
                e.x = 10'(x);
                e.y = 10'(y);
                if (g == 0 && w[2:0] == 3'd1) begin
                    e.op = 2'd0;
                    exp_q.push_back(e);
                    x--;
                    y--;
                end else begin
                    if (g == 0) begin
                        if (w[2:0] == 3'd2 || w[2:0] == 3'd3) g = 1;
                        else if (w[2:0] == 3'd4 || w[2:0] == 3'd5) g = 2;
                        else break;
                    end
                    if (g == 1) begin
                        e.op = 2'd1;
                        exp_q.push_back(e);
                        x--;
                        if (!w[3]) g = 0;
                    end else begin
                        e.op = 2'd2;
                        exp_q.push_back(e);
                        y--;
                        if (!w[4]) g = 0;
                    end
                end
                if (x == 0 || y == 0) break;
            end
        end
        exp_end_x = x;
        exp_end_y = y;
    endtask
    logic           p_stall = 1'b0;
    logic [1:0]     p_op;
    logic [AW-1:0]  p_col;
    logic [MBW-1:0] p_blk;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_i) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_valid", int'(op_valid), 1);
                chk("hold_op", int'(op_o), int'(p_op));
                chk("hold_col", int'(column_num), int'(p_col));
                chk("hold_blk", int'(mem_block_num), int'(p_blk));
            end
            if (op_valid && op_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_op actual=%0d required=none", op_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("op", int'(op_o), int'(e.op));
                    chk("op_col", int'(column_num), int'(e.x));
                    chk("op_blk", int'(mem_block_num), int'(e.y) >> 4);
                end
            end
            if (done) begin
                if (!exp_active) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    chk("end_x", int'(end_x), exp_end_x);
                    chk("end_y", int'(end_y), exp_end_y);
                    chk("ops_left", exp_q.size(), 0);
                end
                exp_active = 1'b0;
            end
            p_stall = op_valid && !op_ready;
            p_op = op_o;
            p_col = column_num;
            p_blk = mem_block_num;
        end
    end
    initial forever begin
        @(posedge clk);
        #1;
        op_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    // drive a walk whose expectations are already in the model; returns start-to-first-op_valid latency
    task automatic run(input int sx, input int sy, input bit second, input bit bp, output int lat);
        bit got;
        int n;
        got = 1'b0;
        lat = -1;
        n = 0;
        exp_active = 1'b1;
        @(posedge clk);
        #1;
        tb_x_i = AW'(sx);
        tb_y_i = AW'(sy);
        start = 1'b1;
        while (!got && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start = 1'b0;
            if (second && n == 3) begin
                chk("busy_mid", int'(busy), 1);
                tb_x_i = AW'(7);
                tb_y_i = AW'(7);
                start = 1'b1;
            end
            if (second && n == 4) start = 1'b0;
            if (op_valid && lat < 0) lat = n;
            if (bp && lat >= 0 && n == lat + 7) rdy_mode = 0;
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done");
        end
        @(posedge clk);
        #1;
        chk("busy_after", int'(busy), 0);
    endtask
    initial begin
        int lat;
        clear_dirm();
        repeat (3) @(posedge clk);
        chk("rst_valid", int'(op_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_end_x", int'(end_x), 0);
        chk("rst_col", int'(column_num), 0);
        chk("rst_blk", int'(mem_block_num), 0);
        #1 reset_i = 1'b1;
        // diagonal walk
        dirm[3][3] = 5'd1;
        dirm[2][2] = 5'd1;
        dirm[1][1] = 5'd1;
        model(3, 3);
        chk("pin_diag_n", exp_q.size(), 3);
        chk("pin_diag_op", int'(exp_q[2].op), 0);
        chk("pin_diag_end", exp_end_x + exp_end_y, 0);
        run(3, 3, 1'b0, 1'b0, lat);
        chk("diag_latency", lat, 4);
        // short gap
        clear_dirm();
        dirm[5][2] = 5'b01010;
        dirm[4][2] = 5'b00010;
        model(5, 2);
        chk("pin_gap_n", exp_q.size(), 2);
        chk("pin_gap_op", int'(exp_q[1].op), 1);
        chk("pin_gap_end_x", exp_end_x, 3);
        run(5, 2, 1'b0, 1'b0, lat);
        chk("gap_latency", lat, 5);
        // long insertion across a block boundary
        clear_dirm();
        dirm[4][17] = 5'b10101;
        dirm[4][16] = 5'b00101;
        model(4, 17);
        chk("pin_ins_n", exp_q.size(), 2);
        chk("pin_ins_op", int'(exp_q[0].op), 2);
        chk("pin_ins_end_y", exp_end_y, 15);
        run(4, 17, 1'b0, 1'b0, lat);
        chk("ins_blk_end", int'(mem_block_num), 0);
        // backpressure on the first op
        clear_dirm();
        dirm[3][3] = 5'd1;
        dirm[2][2] = 5'd1;
        dirm[1][1] = 5'd1;
        model(3, 3);
        rdy_mode = 2;
        run(3, 3, 1'b0, 1'b1, lat);
        rdy_mode = 0;
        // start while busy is ignored
        model(3, 3);
        run(3, 3, 1'b1, 1'b0, lat);
        // illegal source terminates with no op
        dirm[6][6] = 5'd6;
        model(6, 6);
        chk("pin_illegal_n", exp_q.size(), 0);
        run(6, 6, 1'b0, 1'b0, lat);
        // zero coordinate start goes straight to done
        model(0, 5);
        chk("pin_zero_end_y", exp_end_y, 5);
        run(0, 5, 1'b0, 1'b0, lat);
        // asynchronous reset while an op is stalled in EMIT
        model(3, 3);
        exp_active = 1'b1;
        rdy_mode = 2;
        @(posedge clk);
        #1;
        tb_x_i = AW'(3);
        tb_y_i = AW'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !op_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_valid", int'(op_valid), 1);
        #2 reset_i = 1'b0;
        #1;
        chk("arst_valid", int'(op_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_end_x", int'(end_x), 0);
        chk("arst_end_y", int'(end_y), 0);
        exp_q.delete();
        exp_active = 1'b0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b1;
        model(3, 3);
        run(3, 3, 1'b0, 1'b0, lat);
        chk("post_reset_latency", lat, 4);
        // randomized walks with random backpressure
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 64; i++)
                for (int j = 0; j < 64; j++) begin
                    int r;
                    r = int'($urandom_range(0, 15));
                    dirm[i][j][4:3] = 2'($urandom_range(0, 3));
                    dirm[i][j][2:0] = (r == 0) ? 3'd0 : (r == 1) ? 3'(6 + $urandom_range(0, 1)) : 3'(1 + $urandom_range(0, 4));
                end
            rdy_mode = 1;
            model(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)));
            begin
                int sx, sy;
                sx = int'(exp_q.size() > 0 ? exp_q[0].x : 10'(exp_end_x));
                sy = int'(exp_q.size() > 0 ? exp_q[0].y : 10'(exp_end_y));
                run(sx, sy, 1'b0, 1'b0, lat);
            end
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
